com_div_sequencer: RTL and testbench

//  Sequences one shared restoring divider to turn centroid accumulator sums into averages.

---
 rtl/com_pkg.sv | 31 +++
 rtl/com_div_sequencer.sv | 173 +++++++++++++++++
 tb/tb_com_div_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/com_pkg.sv
// Shared types and constants for the centroid divider sequencer.
package com_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        X_REQ  = 3'd2,
        X_WAIT = 3'd3,
        Y_REQ  = 3'd4,
        Y_WAIT = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam int unsigned DEF_ACC_W      = 33;
    localparam int unsigned DEF_CNT_W      = 20;
    localparam int unsigned DEF_X_W        = 11;
    localparam int unsigned DEF_Y_W        = 10;
    localparam int unsigned DEF_ROT_THRESH = 160;
    localparam int unsigned DEF_TIMEOUT    = 64;

    localparam logic [1:0] ROT_LEFT  = 2'b10;
    localparam logic [1:0] ROT_RIGHT = 2'b11;

    // Clamp a quotient to the largest value representable in w bits.
    function automatic logic [63:0] sat_narrow(input logic [63:0] q, input int unsigned w);
        logic [63:0] max_val;
        max_val = (64'd1 << w) - 64'd1;
        return (q > max_val) ? max_val : q;
    endfunction

endpackage

// File: rtl/com_div_sequencer.sv
// Drives a shared divider twice (x then y) to turn centroid sums into averages.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for tabulate_in; sums are snapshotted on the request
// CHECK  | zero pixel count aborts without touching the divider
// X_REQ  | waiting for divider idle, then one-cycle start with x sum
// X_WAIT | waiting for x quotient, watchdog running
// Y_REQ  | waiting for divider idle, then one-cycle start with y sum
// Y_WAIT | waiting for y quotient, watchdog running
// DONE   | publish result or error, tell accumulator to clear
module com_div_sequencer
    import com_pkg::*;
#(
    parameter int unsigned ACC_W      = DEF_ACC_W,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned X_W        = DEF_X_W,
    parameter int unsigned Y_W        = DEF_Y_W,
    parameter int unsigned ROT_THRESH = DEF_ROT_THRESH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             tabulate_in,
    input  logic [ACC_W-1:0] x_acc_in,
    input  logic [ACC_W-1:0] y_acc_in,
    input  logic [CNT_W-1:0] count_in,
    output logic [ACC_W-1:0] div_dividend_out,
    output logic [ACC_W-1:0] div_divisor_out,
    output logic             div_valid_out,
    input  logic [ACC_W-1:0] div_quotient_in,
    input  logic             div_valid_in,
    input  logic             div_error_in,
    input  logic             div_busy_in,
    output logic [X_W-1:0]   x_out,
    output logic [Y_W-1:0]   y_out,
    output logic [1:0]       rotate_out,
    output logic             valid_out,
    output logic             error_out,
    output logic             clear_out,
    output logic             overrun_out,
    output logic             busy_out
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [ACC_W-1:0] x_snap;
    logic [ACC_W-1:0] y_snap;
    logic [CNT_W-1:0] cnt_snap;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic             err;
    logic [WD_W-1:0]  wd_cnt;

    logic [X_W-1:0]   x_sat;
    logic [Y_W-1:0]   y_sat;
    logic             wd_expired;

    assign x_sat      = X_W'(sat_narrow(64'(div_quotient_in), X_W));
    assign y_sat      = Y_W'(sat_narrow(64'(div_quotient_in), Y_W));
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
    assign busy_out   = (state != IDLE);

    // Sequencer FSM with registered divider handshake and result outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= IDLE;
            x_snap           <= '0;
            y_snap           <= '0;
            cnt_snap         <= '0;
            x_q              <= '0;
            y_q              <= '0;
            err              <= 1'b0;
            wd_cnt           <= '0;
            div_dividend_out <= '0;
            div_divisor_out  <= '0;
            div_valid_out    <= 1'b0;
            x_out            <= '0;
            y_out            <= '0;
            rotate_out       <= 2'b00;
            valid_out        <= 1'b0;
            error_out        <= 1'b0;
            clear_out        <= 1'b0;
            overrun_out      <= 1'b0;
        end else begin
            div_valid_out <= 1'b0;
            valid_out     <= 1'b0;
            error_out     <= 1'b0;
            clear_out     <= 1'b0;
            // A request while a sequence is in flight is dropped and flagged.
            overrun_out   <= tabulate_in && (state != IDLE);

            unique case (state)
                IDLE: begin
                    if (tabulate_in) begin
                        x_snap   <= x_acc_in;
                        y_snap   <= y_acc_in;
                        cnt_snap <= count_in;
                        err      <= 1'b0;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (cnt_snap == '0) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= X_REQ;
                    end
                end
                X_REQ: begin
                    if (!div_busy_in) begin
                        div_valid_out    <= 1'b1;
                        div_dividend_out <= x_snap;
                        div_divisor_out  <= ACC_W'(cnt_snap);
                        wd_cnt           <= '0;
                        state            <= X_WAIT;
                    end
                end
                X_WAIT: begin
                    if (div_valid_in) begin
                        x_q   <= x_sat;
                        err   <= err | div_error_in;
                        state <= Y_REQ;
                    end else if (wd_expired) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                Y_REQ: begin
                    if (!div_busy_in) begin
                        div_valid_out    <= 1'b1;
                        div_dividend_out <= y_snap;
                        div_divisor_out  <= ACC_W'(cnt_snap);
                        wd_cnt           <= '0;
                        state            <= Y_WAIT;
                    end
                end
                Y_WAIT: begin
                    if (div_valid_in) begin
                        y_q   <= y_sat;
                        err   <= err | div_error_in;
                        state <= DONE;
                    end else if (wd_expired) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                DONE: begin
                    if (err) begin
                        error_out <= 1'b1;
                    end else begin
                        x_out      <= x_q;
                        y_out      <= y_q;
                        rotate_out <= (x_q <= X_W'(ROT_THRESH)) ? ROT_LEFT : ROT_RIGHT;
                        valid_out  <= 1'b1;
                    end
                    clear_out <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_com_div_sequencer.sv
// Bench for com_div_sequencer: table vectors, corner sequences, random runs vs. a reference model.
module tb_com_div_sequencer;

    localparam int TIMEOUT = 64;

    logic        clk_in;
    logic        rst_n_in;
    logic        tabulate_in;
    logic [32:0] x_acc_in;
    logic [32:0] y_acc_in;
    logic [19:0] count_in;
    logic [32:0] div_dividend_out;
    logic [32:0] div_divisor_out;
    logic        div_valid_out;
    logic [32:0] div_quotient_in;
    logic        div_valid_in;
    logic        div_error_in;
    logic        div_busy_in;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic [1:0]  rotate_out;
    logic        valid_out;
    logic        error_out;
    logic        clear_out;
    logic        overrun_out;
    logic        busy_out;

    com_div_sequencer dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .tabulate_in      (tabulate_in),
        .x_acc_in         (x_acc_in),
        .y_acc_in         (y_acc_in),
        .count_in         (count_in),
        .div_dividend_out (div_dividend_out),
        .div_divisor_out  (div_divisor_out),
        .div_valid_out    (div_valid_out),
        .div_quotient_in  (div_quotient_in),
        .div_valid_in     (div_valid_in),
        .div_error_in     (div_error_in),
        .div_busy_in      (div_busy_in),
        .x_out            (x_out),
        .y_out            (y_out),
        .rotate_out       (rotate_out),
        .valid_out        (valid_out),
        .error_out        (error_out),
        .clear_out        (clear_out),
        .overrun_out      (overrun_out),
        .busy_out         (busy_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Divider behavioural model: answers N negedges after seeing a start.
    int          div_n       = 4;
    bit          div_respond = 1'b1;
    bit          div_inj     = 1'b0;
    logic [32:0] last_dvd    = '0;
    logic [32:0] last_dvs    = '0;

    initial begin
        logic [32:0] dvd;
        logic [32:0] dvs;
        div_valid_in    = 1'b0;
        div_quotient_in = '0;
        div_error_in    = 1'b0;
        forever begin
            @(negedge clk_in);
            if (div_valid_out && div_respond) begin
                dvd      = div_dividend_out;
                dvs      = div_divisor_out;
                last_dvd = dvd;
                last_dvs = dvs;
                repeat (div_n) @(negedge clk_in);
                div_valid_in    = 1'b1;
                div_quotient_in = (dvs == 0) ? '1 : dvd / dvs;
                div_error_in    = div_inj || (dvs == 0);
                @(negedge clk_in);
                div_valid_in    = 1'b0;
                div_error_in    = 1'b0;
            end
        end
    end

    // Pulse counters.
    int n_start = 0, n_valid = 0, n_error = 0, n_clear = 0, n_overrun = 0;
    always @(negedge clk_in) begin
        if (div_valid_out) n_start++;
        if (valid_out)     n_valid++;
        if (error_out)     n_error++;
        if (clear_out)     n_clear++;
        if (overrun_out)   n_overrun++;
    end

    // Reference model state: published centroid held across runs.
    logic [10:0] exp_x   = '0;
    logic [9:0]  exp_y   = '0;
    logic [1:0]  exp_rot = 2'b00;

    function automatic void ref_apply(input logic [32:0] x, input logic [32:0] y,
                                      input logic [19:0] cnt, input int n, input bit inj,
                                      output bit e, output int lat);
        longint unsigned qx, qy;
        if (cnt == 0) begin
            e   = 1'b1;
            lat = 2;
            return;
        end
        lat = 2 * n + 6;
        e   = inj;
        if (inj) return;
        qx      = longint'(x) / longint'(cnt);
        qy      = longint'(y) / longint'(cnt);
        exp_x   = (qx > 2047) ? 11'd2047 : 11'(qx);
        exp_y   = (qy > 1023) ? 10'd1023 : 10'(qy);
        exp_rot = (exp_x <= 11'd160) ? 2'b10 : 2'b11;
    endfunction

    task automatic run_seq(input logic [32:0] x, input logic [32:0] y, input logic [19:0] cnt,
                           input int n, input bit inj, output int k_seen, output int kind);
        div_n    = n;
        div_inj  = inj;
        x_acc_in = x;
        y_acc_in = y;
        count_in = cnt;
        @(negedge clk_in);
        tabulate_in = 1'b1;
        k_seen = -1;
        kind   = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk_in);
            tabulate_in = 1'b0;
            if (valid_out || error_out) begin
                k_seen = k;
                kind   = valid_out ? 1 : 2;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input int k, input int kind,
                                input int exp_k, input bit exp_err,
                                input logic [10:0] ex, input logic [9:0] ey, input logic [1:0] er);
        check({tag, ".kind"}, 64'(kind), exp_err ? 64'd2 : 64'd1);
        check({tag, ".latency"}, 64'(k), 64'(exp_k));
        check({tag, ".x_out"}, 64'(x_out), 64'(ex));
        check({tag, ".y_out"}, 64'(y_out), 64'(ey));
        check({tag, ".rotate"}, 64'(rotate_out), 64'(er));
    endtask

    typedef struct {
        logic [32:0] x;
        logic [32:0] y;
        logic [19:0] cnt;
        int          n;
        bit          inj;
        bit          exp_err;
        int          exp_k;
        logic [10:0] ex;
        logic [9:0]  ey;
        logic [1:0]  erot;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int k, kind, s0, v0, e0, c0, o0, exp_k;
        bit exp_e;
        int early;
        logic [32:0] rx, ry;
        logic [19:0] rc;
        int rn;
        bit rinj;

        vecs[0] = '{33'd1000,  33'd500,   20'd10, 33, 1'b0, 1'b0, 72, 11'd100,  10'd50,   2'b10};
        vecs[1] = '{33'd5,     33'd5,     20'd0,  4,  1'b0, 1'b1, 2,  11'd100,  10'd50,   2'b10};
        vecs[2] = '{33'd30000, 33'd100,   20'd10, 5,  1'b0, 1'b0, 16, 11'd2047, 10'd10,   2'b11};
        vecs[3] = '{33'd1600,  33'd20000, 20'd10, 3,  1'b0, 1'b0, 12, 11'd160,  10'd1023, 2'b10};
        vecs[4] = '{33'd1610,  33'd0,     20'd10, 1,  1'b0, 1'b0, 8,  11'd161,  10'd0,    2'b11};
        vecs[5] = '{33'd500,   33'd500,   20'd5,  2,  1'b1, 1'b1, 10, 11'd161,  10'd0,    2'b11};
        vecs[6] = '{33'd2048,  33'd1024,  20'd1,  4,  1'b0, 1'b0, 14, 11'd2047, 10'd1023, 2'b11};

        rst_n_in    = 1'b0;
        tabulate_in = 1'b0;
        x_acc_in    = '0;
        y_acc_in    = '0;
        count_in    = '0;
        div_busy_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("reset.busy", 64'(busy_out), 0);
        check("reset.div_valid", 64'(div_valid_out), 0);
        check("reset.xy", 64'({x_out, y_out}), 0);
        check("reset.rotate", 64'(rotate_out), 0);
        check("reset.pulses", 64'({valid_out, error_out, clear_out, overrun_out}), 0);
        check("reset.div_operands", 64'({div_dividend_out, div_divisor_out}), 0);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // Table vectors.
        foreach (vecs[i]) begin
            s0 = n_start; c0 = n_clear;
            run_seq(vecs[i].x, vecs[i].y, vecs[i].cnt, vecs[i].n, vecs[i].inj, k, kind);
            repeat (2) @(negedge clk_in);
            check_result($sformatf("vec%0d", i), k, kind, vecs[i].exp_k, vecs[i].exp_err,
                         vecs[i].ex, vecs[i].ey, vecs[i].erot);
            check($sformatf("vec%0d.starts", i), 64'(n_start - s0), (vecs[i].cnt == 0) ? 0 : 2);
            check($sformatf("vec%0d.clears", i), 64'(n_clear - c0), 1);
            check($sformatf("vec%0d.idle", i), 64'(busy_out), 0);
            if (vecs[i].cnt != 0) begin
                check($sformatf("vec%0d.y_dividend", i), 64'(last_dvd), 64'(vecs[i].y));
                check($sformatf("vec%0d.divisor", i), 64'(last_dvs), 64'(vecs[i].cnt));
            end
        end
        exp_x = 11'd2047; exp_y = 10'd1023; exp_rot = 2'b11;

        // Divider never answers: watchdog aborts the X division.
        div_respond = 1'b0;
        s0 = n_start;
        run_seq(33'd100, 33'd1, 20'd1, 4, 1'b0, k, kind);
        repeat (2) @(negedge clk_in);
        check_result("timeout", k, kind, TIMEOUT + 3, 1'b1, exp_x, exp_y, exp_rot);
        check("timeout.starts", 64'(n_start - s0), 1);
        check("timeout.idle", 64'(busy_out), 0);
        div_respond = 1'b1;
        repeat (2) @(negedge clk_in);

        // Divider busy for 20 cycles before the X request.
        s0 = n_start;
        div_n = 2; div_inj = 1'b0;
        x_acc_in = 33'd900; y_acc_in = 33'd90; count_in = 20'd9;
        div_busy_in = 1'b1;
        @(negedge clk_in);
        tabulate_in = 1'b1;
        early = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            tabulate_in = 1'b0;
            if (div_valid_out) early++;
        end
        check("busy.no_request", 64'(early), 0);
        div_busy_in = 1'b0;
        @(negedge clk_in);
        check("busy.request_next", 64'(div_valid_out), 1);
        kind = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (valid_out || error_out) begin
                kind = valid_out ? 1 : 2;
                break;
            end
        end
        repeat (2) @(negedge clk_in);
        ref_apply(33'd900, 33'd90, 20'd9, 2, 1'b0, exp_e, exp_k);
        check("busy.kind", 64'(kind), 1);
        check("busy.x_out", 64'(x_out), 64'(exp_x));
        check("busy.y_out", 64'(y_out), 64'(exp_y));
        check("busy.starts", 64'(n_start - s0), 2);

        // Second tabulate while waiting on the X quotient.
        o0 = n_overrun;
        div_n = 10;
        x_acc_in = 33'd400; y_acc_in = 33'd300; count_in = 20'd4;
        @(negedge clk_in);
        tabulate_in = 1'b1;
        k = -1; kind = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (i == 6) check("overrun.pulse", 64'(overrun_out), 1);
            tabulate_in = (i == 5);
            if (i == 5) begin
                x_acc_in = 33'd7777; y_acc_in = 33'd1; count_in = 20'd1;
            end
            if (valid_out || error_out) begin
                k = i;
                kind = valid_out ? 1 : 2;
                break;
            end
        end
        repeat (2) @(negedge clk_in);
        ref_apply(33'd400, 33'd300, 20'd4, 10, 1'b0, exp_e, exp_k);
        check_result("overrun", k, kind, exp_k, exp_e, exp_x, exp_y, exp_rot);
        check("overrun.count", 64'(n_overrun - o0), 1);

        // Random runs against the reference model.
        for (int it = 0; it < 40; it++) begin
            rn   = int'($urandom_range(1, 8));
            rinj = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) begin
                rc = '0;
                rx = 33'($urandom());
                ry = 33'($urandom());
            end else if ($urandom_range(0, 4) == 0) begin
                rc = 20'($urandom_range(1, 20'hFFFFF));
                rx = {1'($urandom()), 32'($urandom())};
                ry = {1'($urandom()), 32'($urandom())};
            end else begin
                rc = 20'($urandom_range(1, 1000));
                rx = 33'(rc * $urandom_range(0, 2500) + $urandom_range(0, rc - 1));
                ry = 33'(rc * $urandom_range(0, 1200) + $urandom_range(0, rc - 1));
            end
            c0 = n_clear;
            run_seq(rx, ry, rc, rn, rinj, k, kind);
            repeat (2) @(negedge clk_in);
            ref_apply(rx, ry, rc, rn, rinj, exp_e, exp_k);
            check_result($sformatf("rand%0d", it), k, kind, exp_k, exp_e, exp_x, exp_y, exp_rot);
            check($sformatf("rand%0d.clears", it), 64'(n_clear - c0), 1);
        end

        // Reset asserted while waiting on the Y quotient.
        v0 = n_valid; e0 = n_error; c0 = n_clear;
        div_n = 10; div_inj = 1'b0;
        x_acc_in = 33'd600; y_acc_in = 33'd40; count_in = 20'd2;
        @(negedge clk_in);
        tabulate_in = 1'b1;
        for (int i = 0; i <= 18; i++) begin
            @(negedge clk_in);
            tabulate_in = 1'b0;
        end
        rst_n_in = 1'b0;
        #1;
        check("midreset.xy", 64'({x_out, y_out}), 0);
        check("midreset.rotate", 64'(rotate_out), 0);
        check("midreset.busy", 64'(busy_out), 0);
        check("midreset.div", 64'({div_valid_out, div_dividend_out}), 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (40) @(negedge clk_in);
        check("midreset.no_pulses", 64'((n_valid - v0) + (n_error - e0) + (n_clear - c0)), 0);
        check("midreset.idle", 64'(busy_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
